car_sensor_driver: RTL

- Generates the two-sensor gate waveform (outer/inner photo-sensors) that the occupancy car counter decodes. This block is the transmit side of that protocol.
- Accepts a one-cycle "car enter" or "car exit" request and plays out the 4-phase sensor sequence, holding each phase for a programmable number of cycles.
- Keeps a saturating expected-occupancy count for self-check.
- Drives the V_GPIO sensor pins during board demos, and is the stimulus engine for occupancy benches.

---
 rtl/car_sensor_driver_pkg.sv | 34 +++
 rtl/car_sensor_driver_if.sv | 27 ++
 rtl/car_sensor_driver_hold_timer.sv | 35 +++
 rtl/car_sensor_driver.sv | 109 ++++++++++
 4 files changed

// File: rtl/car_sensor_driver_pkg.sv
// Shared types and constants for the car sensor waveform generator.
// Sensor patterns are packed as {outer, inner}.
package car_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PH_FIRST = 3'd1,
    PH_BOTH  = 3'd2,
    PH_LAST  = 3'd3,
    PH_CLEAR = 3'd4
  } state_t;

  localparam logic [1:0] SNS_NONE  = 2'b00;
  localparam logic [1:0] SNS_OUTER = 2'b10;
  localparam logic [1:0] SNS_INNER = 2'b01;
  localparam logic [1:0] SNS_BOTH  = 2'b11;

  localparam logic DIR_ENTER = 1'b1;
  localparam logic DIR_EXIT  = 1'b0;

  // An enter blocks the outer beam first; an exit mirrors the sequence.
  function automatic logic [1:0] sensor_pattern(input state_t s, input logic d);
    logic [1:0] pat;
    pat = SNS_NONE;
    case (s)
      PH_FIRST: pat = (d == DIR_ENTER) ? SNS_OUTER : SNS_INNER;
      PH_BOTH:  pat = SNS_BOTH;
      PH_LAST:  pat = (d == DIR_ENTER) ? SNS_INNER : SNS_OUTER;
      default:  pat = SNS_NONE;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/car_sensor_driver_if.sv
// Request/status bundle between a requester (master) and the sensor driver (slave).
interface car_sensor_driver_if
  import car_sensor_pkg::*;
#(
  parameter int CNT_W = 5
);
  // start is a one-cycle strobe, taken only when busy==0; dir is sampled with it.
  // busy stays high until the done pulse, during which a new start is accepted.
  logic             start;
  logic             dir;
  logic             outer;
  logic             inner;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] expected_count;
  state_t           state_dbg;

  modport master (
    output start, dir,
    input  outer, inner, busy, done, expected_count, state_dbg
  );

  modport slave (
    input  start, dir,
    output outer, inner, busy, done, expected_count, state_dbg
  );
endinterface

// File: rtl/car_sensor_driver_hold_timer.sv
// Loadable down-counter that flags the last cycle of a sensor phase.
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);
  // Keep at least one bit so HOLD_CYCLES==1 still elaborates.
  localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(HOLD_CYCLES - 1);
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/car_sensor_driver.sv
// Plays out the 4-phase outer/inner sensor waveform for one car and tracks the
// occupancy that completed sequences imply.
module car_sensor_driver
  import car_sensor_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_COUNT   = 16,
  parameter int CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  car_sensor_driver_if.slave   bus
);
  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             outer_q, outer_d;
  logic             inner_q, inner_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tmr_load;
  logic             tmr_enable;
  logic             tmr_expire;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .enable (tmr_enable),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    count_d    = count_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = PH_FIRST;
          dir_d    = bus.dir;
          tmr_load = 1'b1;
        end
      end
      PH_FIRST, PH_BOTH, PH_LAST: begin
        tmr_enable = !tmr_expire;
        if (tmr_expire) begin
          tmr_load = 1'b1;
          case (state_q)
            PH_FIRST: state_d = PH_BOTH;
            PH_BOTH:  state_d = PH_LAST;
            default:  state_d = PH_CLEAR;
          endcase
        end
      end
      PH_CLEAR: begin
        tmr_enable = !tmr_expire;
        if (tmr_expire) begin
          state_d = IDLE;
          done_d  = 1'b1;
          // Clamp before stepping so the count never wraps.
          if (dir_q == DIR_ENTER) begin
            if (count_q < CNT_W'(MAX_COUNT)) count_d = count_q + CNT_W'(1);
          end else begin
            if (count_q != '0) count_d = count_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    {outer_d, inner_d} = sensor_pattern(state_d, dir_d);
    busy_d             = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_EXIT;
      outer_q <= 1'b0;
      inner_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      outer_q <= outer_d;
      inner_q <= inner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign bus.outer          = outer_q;
  assign bus.inner          = inner_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.expected_count = count_q;
  assign bus.state_dbg      = state_q;
endmodule
